// File: rtl/data_out_gather_pkg.sv
// Shared constants and types for the output chunk collector.
`ifndef CONSTS_VH
`include "consts.vh"
`endif

package data_out_gather_pkg;

    localparam int unsigned N_CHUNK    = `N_CHUNK;
    localparam int unsigned BUF_CHUNKS = N_CHUNK - 1;

    typedef logic [1:0] chunk_cnt_t;

    localparam chunk_cnt_t LAST_CHUNK = 2'(N_CHUNK - 1);

endpackage

// File: rtl/consts.vh
// Shared layer dimensions for the mixing datapath and its neighbours.
`ifndef CONSTS_VH
`define CONSTS_VH

`ifndef DATA_N
`define DATA_N 2
`endif

`ifndef N_LEN
`define N_LEN 8
`endif

`ifndef HID_DIM
`define HID_DIM 8
`endif

`define N_CHUNK 4

`endif

// File: rtl/data_out_gather.sv
// Collects DATA_N-element chunks into a HID_DIM-element vector; chunk k fills
// slice k, and the completed vector sits in a one-entry valid/ready register.
module data_out_gather
    import data_out_gather_pkg::*;
#(
    parameter int unsigned DATA_N  = `DATA_N,
    parameter int unsigned N_LEN   = `N_LEN,
    parameter int unsigned HID_DIM = `HID_DIM
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_N*N_LEN-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [HID_DIM*N_LEN-1:0]    out_data,
    output logic                        busy
);

    localparam int unsigned CHUNK_W = DATA_N * N_LEN;

    if (HID_DIM != N_CHUNK * DATA_N) begin : g_dim_check
        $error("data_out_gather: HID_DIM must equal N_CHUNK*DATA_N");
    end

    chunk_cnt_t                          cnt;
    logic [BUF_CHUNKS-1:0][CHUNK_W-1:0]  asm_buf;
    logic                                last_chunk;
    logic                                accept;
    logic                                complete;

    assign last_chunk = (cnt == LAST_CHUNK);
    // Only the completing chunk can stall, and only while the output is full.
    assign in_ready   = run && !(last_chunk && out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign complete   = accept && last_chunk;
    assign busy       = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            asm_buf   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (!run) begin
            cnt       <= '0;
            asm_buf   <= '0;
            out_valid <= 1'b0;
        end else begin
            // A completing chunk in the consume cycle reloads and keeps valid high.
            if (out_valid && out_ready && !complete) begin
                out_valid <= 1'b0;
            end
            if (complete) begin
                out_data  <= {in_data, asm_buf};
                out_valid <= 1'b1;
                cnt       <= '0;
            end else if (accept) begin
                for (int unsigned i = 0; i < BUF_CHUNKS; i++) begin
                    if (cnt == 2'(i)) begin
                        asm_buf[i] <= in_data;
                    end
                end
                cnt <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_out_gather.sv
// Self-checking bench for data_out_gather against a queue-based reference model.
module tb_data_out_gather;

    localparam int unsigned DN = 2;
    localparam int unsigned NL = 8;
    localparam int unsigned HD = 8;
    localparam int unsigned CW = DN * NL;
    localparam int unsigned VW = HD * NL;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          busy;

    int n_cmp;
    int n_fail;

    // Reference model: chunks received toward the current vector, plus the output slot.
    logic [CW-1:0] pq[$];
    logic          m_valid;
    logic [VW-1:0] m_data;
    logic          exp_rdy;
    logic          obs_rdy;

    data_out_gather #(
        .DATA_N (DN),
        .N_LEN  (NL),
        .HID_DIM(HD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Applies one cycle of inputs, samples in_ready, clocks, and advances the model.
    task automatic drive_cycle(input logic r, input logic v, input logic [CW-1:0] d,
                               input logic ordy);
        run       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = r && !(pq.size() == 3 && m_valid && !ordy);
        obs_rdy = in_ready;
        @(posedge clk);
        if (!r) begin
            pq.delete();
            m_valid = 1'b0;
        end else begin
            if (m_valid && ordy) m_valid = 1'b0;
            if (v && exp_rdy) begin
                pq.push_back(d);
                if (pq.size() == 4) begin
                    m_data  = {pq[3], pq[2], pq[1], pq[0]};
                    m_valid = 1'b1;
                    pq.delete();
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        pq.delete(); m_valid = 1'b0; m_data = '0;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [CW-1:0] c [4];
        c = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'b1, c[k], 1'b1);
            n_cmp++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready k=%0d got=%b exp=1", k, obs_rdy); end
            n_cmp++; if (out_valid !== (k == 3)) begin n_fail++; $display("FAIL basic_out_valid k=%0d got=%b exp=%b", k, out_valid, (k == 3)); end
        end
        n_cmp++; if (out_data !== 64'h0706050403020100) begin n_fail++; $display("FAIL basic_out_data got=%h exp=0706050403020100", out_data); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse got=%b exp=0", out_valid); end
    endtask

    task automatic test_gaps();
        logic [CW-1:0] c [4];
        c = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'b1, c[k], 1'b1);
            n_cmp++; if (busy !== (k < 3)) begin n_fail++; $display("FAIL gaps_busy_chunk k=%0d got=%b exp=%b", k, busy, (k < 3)); end
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    drive_cycle(1'b1, 1'b0, 16'($urandom), 1'b1);
                    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gaps_busy_idle k=%0d got=%b exp=1", k, busy); end
                    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_out_valid k=%0d got=%b exp=0", k, out_valid); end
                end
            end
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_done got=%b exp=1", out_valid); end
        n_cmp++; if (out_data !== 64'h0706050403020100) begin n_fail++; $display("FAIL gaps_out_data got=%h exp=0706050403020100", out_data); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] a [4];
        logic [CW-1:0] b [4];
        logic [VW-1:0] a_vec, b_vec;
        for (int k = 0; k < 4; k++) begin a[k] = 16'($urandom); b[k] = 16'($urandom); end
        a_vec = {a[3], a[2], a[1], a[0]};
        b_vec = {b[3], b[2], b[1], b[0]};
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, a[k], 1'b0);
        n_cmp++; if (out_data !== a_vec) begin n_fail++; $display("FAIL bp_a_data got=%h exp=%h", out_data, a_vec); end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b1, b[k], 1'b0);
            n_cmp++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_b_chunk_ready k=%0d got=%b exp=1", k, obs_rdy); end
        end
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1'b1, 1'b1, b[3], 1'b0);
            n_cmp++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got=%b exp=0", obs_rdy); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
            n_cmp++; if (out_data !== a_vec) begin n_fail++; $display("FAIL bp_hold_data got=%h exp=%h", out_data, a_vec); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold_busy got=%b exp=1", busy); end
        end
        drive_cycle(1'b1, 1'b1, b[3], 1'b1);
        n_cmp++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", obs_rdy); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_data !== b_vec) begin n_fail++; $display("FAIL bp_b_data got=%h exp=%h", out_data, b_vec); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_b_busy got=%b exp=0", busy); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 2; k++) drive_cycle(1'b1, 1'b1, 16'($urandom), 1'b1);
        drive_cycle(1'b0, 1'b1, 16'($urandom), 1'b1);
        n_cmp++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_ready got=%b exp=0", obs_rdy); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, 16'hAAAA, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_data !== 64'hAAAAAAAAAAAAAAAA) begin n_fail++; $display("FAIL abort_data got=%h exp=aaaaaaaaaaaaaaaa", out_data); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic test_run_drop_on_complete();
        logic [CW-1:0] a [4];
        logic [VW-1:0] a_vec;
        for (int k = 0; k < 4; k++) a[k] = 16'($urandom);
        a_vec = {a[3], a[2], a[1], a[0]};
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, a[k], 1'b0);
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
        drive_cycle(1'b0, 1'b1, 16'($urandom), 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rundrop_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== a_vec) begin n_fail++; $display("FAIL rundrop_data_hold got=%h exp=%h", out_data, a_vec); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rundrop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        logic [CW-1:0] c [4];
        logic [VW-1:0] c_vec;
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b1, 16'($urandom), 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL areset_setup got=%b%b exp=11", out_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", busy); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL areset_data got=%h exp=0", out_data); end
        pq.delete(); m_valid = 1'b0; m_data = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) c[k] = 16'($urandom);
        c_vec = {c[3], c[2], c[1], c[0]};
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, c[k], 1'b1);
        n_cmp++; if (out_data !== c_vec) begin n_fail++; $display("FAIL areset_first_vec got=%h exp=%h", out_data, c_vec); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] c [8];
        logic [VW-1:0] v0, v1;
        for (int k = 0; k < 8; k++) c[k] = 16'($urandom);
        v0 = {c[3], c[2], c[1], c[0]};
        v1 = {c[7], c[6], c[5], c[4]};
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b1, 1'b1, c[k], 1'b1);
            n_cmp++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, obs_rdy); end
            n_cmp++; if (out_valid !== (k == 3 || k == 7)) begin n_fail++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, out_valid, (k == 3 || k == 7)); end
            if (k == 3) begin
                n_cmp++; if (out_data !== v0) begin n_fail++; $display("FAIL b2b_vec0 got=%h exp=%h", out_data, v0); end
            end
            if (k == 7) begin
                n_cmp++; if (out_data !== v1) begin n_fail++; $display("FAIL b2b_vec1 got=%h exp=%h", out_data, v1); end
            end
        end
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
                        16'($urandom), 1'($urandom));
            n_cmp++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
            n_cmp++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, out_valid, m_valid); end
            n_cmp++; if (out_data !== m_data) begin n_fail++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, out_data, m_data); end
            n_cmp++; if (busy !== (pq.size() != 0)) begin n_fail++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, (pq.size() != 0)); end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_abort();
        test_run_drop_on_complete();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_out_gather.md
# data_out_gather

Mixing-layer output collector, the inverse of the input chunk source: accepts `DATA_N`-element chunks, one per accepted beat, and reassembles them into a full `HID_DIM`-element vector. Chunk k fills element slice k, so chunk 0 lands in the lowest slice. The assembled vector is presented on a valid/ready output with a one-entry output register. Assembly can therefore continue while the previous vector waits to be consumed. It sits between the mixing datapath and the next layer's input register.

## Interface
- `DATA_N`, default `` `DATA_N ``: elements per chunk.
- `N_LEN`, default `` `N_LEN ``: bits per element.
- `HID_DIM`, default `` `HID_DIM ``: elements per full vector; must equal 4*`DATA_N`.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `run`, input, 1: enable; low aborts any partial vector.
- `in_valid`, input, 1: `in_data` carries a chunk.
- `in_ready`, output, 1: chunk is accepted when `in_valid && in_ready`.
- `in_data`, input, `DATA_N*N_LEN`: chunk payload.
- `out_valid`, output, 1: `out_data` holds a complete, unconsumed vector.
- `out_ready`, input, 1: consumer takes the vector when `out_valid && out_ready`.
- `out_data`, output, `HID_DIM*N_LEN`: assembled vector.
- `busy`, output, 1: partial vector in progress (`cnt != 0`).

## Operation
- State:
  - 2-bit chunk counter `cnt` (0..3).
  - Assembly buffer `asm_buf`: 3 chunks; slice 3 is written directly into the output.
  - Output register `out_data`, with flag `out_valid`.
- Accept (`run && in_valid && in_ready`):
  - `cnt` 0..2: write `in_data` into `asm_buf` slice `cnt`; `cnt` increments.
  - `cnt` 3: `out_data <= {in_data, asm_buf[2], asm_buf[1], asm_buf[0]}`; `out_valid <= 1`; `cnt` wraps to 0.
- `in_ready = run && !(cnt==3 && out_valid && !out_ready)`. Chunks 0..2 are never stalled; only the completing chunk waits for output space.
- Output consume (`out_valid && out_ready`) clears `out_valid`, unless a completing chunk is accepted in the same cycle. In that case the new vector loads and `out_valid` stays 1.
- `in_valid` low: no state change; gaps between chunks are allowed at any count.
- `run` low (synchronous):
  - `cnt <= 0`, `asm_buf <= 0`, `out_valid <= 0`; the partial vector and any pending output are discarded.
  - `out_data` holds its last value.
  - `in_ready = 0`.
- Reset values: `cnt=0`, `asm_buf=0`, `out_data=0`, `out_valid=0`, `busy=0`. `in_ready` follows its equation, so it is 0 while `run` is low.
- No arithmetic is performed; payload bits pass through unmodified. Slice k occupies bits `[k*DATA_N*N_LEN +: DATA_N*N_LEN]`.

## Timing
- Latency: the fourth chunk is accepted at edge E, and `out_valid` and `out_data` are visible after E (zero added cycles).
- Sustained throughput: one vector per 4 cycles with `in_valid` and `out_ready` held high, no bubbles.
- `in_ready` is combinational from `run`, `cnt`, `out_valid`, `out_ready`; it has no path from `in_valid`.
- `out_valid` is registered.
- Reset assertion mid-assembly clears everything immediately, asynchronously. The first chunk after release goes to slice 0.
- `run` dropping in the same cycle as a completing chunk: `run` wins; nothing loads and `out_valid` becomes 0.

## Structure
- `DATA_N`, `N_LEN`, `HID_DIM` come from the shared `consts.vh`. Add a chunk-count constant `` `N_CHUNK `` (=4) there, and a compile-time check that `HID_DIM == N_CHUNK*DATA_N`.
- Single module, no sub-module.

## Test plan
Bench configuration: `DATA_N=2`, `N_LEN=8`, `HID_DIM=8`.
- Basic assembly: `run=1`, `in_valid=1`, `out_ready=1`, chunks 16'h0100, 16'h0302, 16'h0504, 16'h0706 -> `out_valid` high for exactly 1 cycle after the 4th edge; `out_data`=64'h0706050403020100.
- Gaps: same chunks with `in_valid` low for 2 cycles between each -> same `out_data`; `busy` is 1 from after chunk 0 until after chunk 3.
- Backpressure: `out_ready=0` and two full vectors A, B supplied -> A held; chunks 0..2 of B accepted; `in_ready=0` at chunk 3. Raise `out_ready` for one cycle -> B chunk 3 accepted that cycle; `out_data`=B; `out_valid` stays 1.
- Abort: after 2 chunks drop `run` for 1 cycle, then send chunks 16'hAAAA ×4 -> `out_data`=64'hAAAAAAAAAAAAAAAA; no stale slices.
- Async reset during a pending output: assert `rst_n=0` mid-cycle -> `out_valid`, `busy` and `out_data` go to 0 immediately, without a clock edge.
- Back-to-back: 8 consecutive chunks with `out_ready=1` -> 2 vectors, `out_valid` pulses 4 cycles apart, `in_ready` never deasserts.
